// File: rtl/jericalla_pkg.sv
// Shared definitions for the jericalla fetch stage: opcodes, special words,
// instruction field positions and the "writes a register" predicate.
package jericalla_pkg;

    localparam int INSTR_W = 18;
    localparam int REG_W   = 5;

    // Field positions inside an instruction word.
    localparam int OP_HI  = 17;
    localparam int OP_LO  = 15;
    localparam int WA_HI  = 14;
    localparam int WA_LO  = 10;
    localparam int RA1_HI = 9;
    localparam int RA1_LO = 5;
    localparam int RA2_HI = 4;
    localparam int RA2_LO = 0;

    // Opcodes. ALU0..ALU4 write the register bank, the rest do not.
    localparam logic [2:0] OP_ALU0 = 3'b000;
    localparam logic [2:0] OP_ALU1 = 3'b001;
    localparam logic [2:0] OP_ALU2 = 3'b010;
    localparam logic [2:0] OP_ALU3 = 3'b011;
    localparam logic [2:0] OP_ALU4 = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_RSV  = 3'b110;
    localparam logic [2:0] OP_SYS  = 3'b111;

    localparam logic [INSTR_W-1:0] NOP_WORD  = 18'h38000;
    localparam logic [INSTR_W-1:0] HALT_WORD = 18'h3FFFF;

    // True when an instruction with this opcode writes its WA register.
    function automatic logic writes_br(input logic [2:0] opcode);
        logic wr;
        case (opcode)
            OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3, OP_ALU4: wr = 1'b1;
            OP_SW, OP_RSV, OP_SYS:                       wr = 1'b0;
            default:                                     wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/jericalla_hazard_window.sv
// Tracks the destination registers of the last HAZ_DEPTH issue slots and
// flags a read-after-write hazard for the candidate instruction.
// A slot is shifted in every cycle; bubbles and non-writing instructions
// shift in an invalid slot, so the window drains naturally over time.
module jericalla_hazard_window
    import jericalla_pkg::*;
#(
    parameter int HAZ_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shift_valid_i,
    input  logic [REG_W-1:0] shift_wa_i,
    input  logic [REG_W-1:0] ra1_i,
    input  logic [REG_W-1:0] ra2_i,
    output logic             hazard_o
);

    logic [HAZ_DEPTH-1:0]            valid_q, valid_d;
    logic [HAZ_DEPTH-1:0][REG_W-1:0] wa_q, wa_d;

    // Next history: new slot enters at index 0, the oldest falls off the end.
    always_comb begin
        valid_d    = valid_q;
        wa_d       = wa_q;
        valid_d[0] = shift_valid_i;
        wa_d[0]    = shift_wa_i;
        for (int i = 1; i < HAZ_DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            wa_d[i]    = wa_q[i-1];
        end
    end

    // History register; reset invalidates every slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            wa_q    <= '0;
        end else begin
            valid_q <= valid_d;
            wa_q    <= wa_d;
        end
    end

    // Any valid pending write whose address matches either source operand.
    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (valid_q[i] && ((wa_q[i] == ra1_i) || (wa_q[i] == ra2_i))) begin
                hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jericalla_fetch.sv
// Instruction-fetch stage for the jericalla datapath: loadable program
// memory, program counter, registered instruction output and RAW interlock
// by NOP bubbles. Optional issue/bubble counters are built when the macro
// JERICALLA_FETCH_PERF_EN is defined.
// Priority each cycle: frozen/halted, HALT fetch, hazard bubble, issue.
module jericalla_fetch
    import jericalla_pkg::*;
#(
    parameter int PROG_DEPTH = 64,
    parameter int PC_W       = 6,
    parameter int HAZ_DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [INSTR_W-1:0] instruccion,
    output logic [PC_W-1:0]    pc_out,
    output logic               stall,
    output logic               halted
`ifdef JERICALLA_FETCH_PERF_EN
    ,
    output logic [15:0]        issued_cnt,
    output logic [15:0]        bubble_cnt
`endif
);

    logic [INSTR_W-1:0] mem_q [PROG_DEPTH];

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               stall_q, stall_d;
    logic               halted_q, halted_d;

    logic [INSTR_W-1:0] cand;
    logic               hazard;
    logic               shift_valid;
    logic               do_issue;
    logic               do_bubble;

    // Program memory write port; loads are only accepted while frozen.
    // Memory is deliberately not reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (prog_we && !run) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign cand = mem_q[pc_q];

    jericalla_hazard_window #(
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_hazard (
        .clk_i         (clk),
        .rst_i         (rst),
        .shift_valid_i (shift_valid),
        .shift_wa_i    (cand[WA_HI:WA_LO]),
        .ra1_i         (cand[RA1_HI:RA1_LO]),
        .ra2_i         (cand[RA2_HI:RA2_LO]),
        .hazard_o      (hazard)
    );

    // Issue decision in priority order; every non-issue case emits a NOP
    // and shifts an invalid slot into the hazard window.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = NOP_WORD;
        stall_d     = 1'b0;
        halted_d    = halted_q;
        shift_valid = 1'b0;
        do_issue    = 1'b0;
        do_bubble   = 1'b0;
        if (halted_q || !run) begin
            // frozen: hold pc, issue NOP
        end else if (cand == HALT_WORD) begin
            halted_d = 1'b1;
        end else if (hazard) begin
            stall_d   = 1'b1;
            do_bubble = 1'b1;
        end else begin
            instr_d     = cand;
            pc_d        = pc_q + PC_W'(1);
            shift_valid = writes_br(cand[OP_HI:OP_LO]);
            do_issue    = 1'b1;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            instr_q  <= NOP_WORD;
            stall_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            stall_q  <= stall_d;
            halted_q <= halted_d;
        end
    end

    assign instruccion = instr_q;
    assign pc_out      = pc_q;
    assign stall       = stall_q;
    assign halted      = halted_q;

`ifdef JERICALLA_FETCH_PERF_EN
    logic [15:0] issued_q;
    logic [15:0] bubble_q;

    // Saturating issue and bubble counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            bubble_q <= '0;
        end else begin
            if (do_issue && (issued_q != 16'hFFFF)) begin
                issued_q <= issued_q + 16'd1;
            end
            if (do_bubble && (bubble_q != 16'hFFFF)) begin
                bubble_q <= bubble_q + 16'd1;
            end
        end
    end

    assign issued_cnt = issued_q;
    assign bubble_cnt = bubble_q;
`else
    logic unused_perf;
    assign unused_perf = do_issue ^ do_bubble;
`endif

endmodule

// File: tb/tb_jericalla_fetch.sv
// Bench for jericalla_fetch: directed programs from the block's usage
// scenarios plus randomized programs, checked against a timestamp-based
// reference model through an expected queue.
module tb_jericalla_fetch;
    import jericalla_pkg::*;

    localparam int PC_W  = 6;
    localparam int DEPTH = 64;
    localparam int HAZ   = 2;
`ifdef JERICALLA_FETCH_PERF_EN
    localparam int EW = 18 + PC_W + 2 + 32;
`else
    localparam int EW = 18 + PC_W + 2;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic              prog_we = 1'b0;
    logic [PC_W-1:0]   prog_addr = '0;
    logic [17:0]       prog_data = '0;
    logic [17:0]       instruccion;
    logic [PC_W-1:0]   pc_out;
    logic              stall;
    logic              halted;
`ifdef JERICALLA_FETCH_PERF_EN
    logic [15:0]       issued_cnt;
    logic [15:0]       bubble_cnt;
`endif

    jericalla_fetch #(
        .PROG_DEPTH (DEPTH),
        .PC_W       (PC_W),
        .HAZ_DEPTH  (HAZ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruccion (instruccion),
        .pc_out      (pc_out),
        .stall       (stall),
        .halted      (halted)
`ifdef JERICALLA_FETCH_PERF_EN
        ,
        .issued_cnt  (issued_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Hazard rule in time terms: a register written by an instruction issued
    // at cycle t may be read by an instruction issuing at cycle c only when
    // c - t > HAZ. Every clock edge counts as a cycle.
    logic [17:0] m_mem [DEPTH];
    int m_pc = 0;
    bit m_halted = 0;
    int m_lw [32];
    int m_cyc = 0;
    int m_issued = 0;
    int m_bubble = 0;

    // One clock cycle of stimulus; also advances the model and queues the
    // outputs expected after the coming rising edge.
    task automatic step(input bit r, input bit rn, input bit we, input int addr,
                        input logic [17:0] data);
        logic [17:0] cand;
        logic [17:0] e_instr;
        bit e_stall;
        logic [EW-1:0] e;
        @(negedge clk);
        rst = r;
        run = rn;
        prog_we = we;
        prog_addr = addr[PC_W-1:0];
        prog_data = data;

        cand = m_mem[m_pc];
        e_instr = NOP_WORD;
        e_stall = 0;
        if (r) begin
            m_pc = 0;
            m_halted = 0;
            for (int i = 0; i < 32; i++) m_lw[i] = -1000;
            m_issued = 0;
            m_bubble = 0;
        end else if (m_halted || !rn) begin
            // frozen
        end else if (cand == HALT_WORD) begin
            m_halted = 1;
        end else if ((m_cyc - m_lw[cand[9:5]] <= HAZ) ||
                     (m_cyc - m_lw[cand[4:0]] <= HAZ)) begin
            e_stall = 1;
            if (m_bubble < 65535) m_bubble++;
        end else begin
            e_instr = cand;
            m_pc = (m_pc + 1) % DEPTH;
            if (cand[17:15] <= 3'd4) m_lw[cand[14:10]] = m_cyc;
            if (m_issued < 65535) m_issued++;
        end
        if (we && !rn) m_mem[addr % DEPTH] = data;
        m_cyc++;

`ifdef JERICALLA_FETCH_PERF_EN
        e = {e_instr, m_pc[PC_W-1:0], e_stall, m_halted, m_issued[15:0], m_bubble[15:0]};
`else
        e = {e_instr, m_pc[PC_W-1:0], e_stall, m_halted};
`endif
        exp_q.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        step(1, 0, 0, 0, 18'h0);
    endtask

    task automatic load(input int addr, input logic [17:0] data);
        step(0, 0, 1, addr, data);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 18'h0);
    endtask

    function automatic logic [17:0] mk(input int op, input int wa, input int ra1, input int ra2);
        logic [2:0] o;
        logic [4:0] a, b, c;
        o = op[2:0];
        a = wa[4:0];
        b = ra1[4:0];
        c = ra2[4:0];
        return {o, a, b, c};
    endfunction

    // ---------------- monitor / checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [EW-1:0] e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
`ifdef JERICALLA_FETCH_PERF_EN
            chk("instruccion", 32'(instruccion), 32'(e[EW-1 -: 18]));
            chk("pc_out",      32'(pc_out),      32'(e[EW-19 -: PC_W]));
            chk("stall",       32'(stall),       32'(e[33]));
            chk("halted",      32'(halted),      32'(e[32]));
            chk("issued_cnt",  32'(issued_cnt),  32'(e[31:16]));
            chk("bubble_cnt",  32'(bubble_cnt),  32'(e[15:0]));
`else
            chk("instruccion", 32'(instruccion), 32'(e[EW-1 -: 18]));
            chk("pc_out",      32'(pc_out),      32'(e[EW-19 -: PC_W]));
            chk("stall",       32'(stall),       32'(e[1]));
            chk("halted",      32'(halted),      32'(e[0]));
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 32; i++) m_lw[i] = -1000;

        // Reset, then fill the whole memory with NOPs.
        do_reset();
        do_reset();
        for (int a = 0; a < DEPTH; a++) load(a, NOP_WORD);

        // Two instructions then HALT.
        load(0, 18'h04443);
        load(1, 18'h08C85);
        load(2, HALT_WORD);
        do_reset();
        run_cycles(8);

        // RAW hazard on R5: two bubbles, then the consumer issues.
        do_reset();
        load(0, mk(0, 5, 1, 2));
        load(1, mk(1, 6, 5, 3));
        load(2, HALT_WORD);
        do_reset();
        run_cycles(8);

        // Store does not write R5: back-to-back issue.
        do_reset();
        load(0, mk(5, 5, 1, 2));
        load(1, mk(1, 6, 5, 3));
        do_reset();
        run_cycles(6);

        // run dropped for 3 cycles; writes accepted only while frozen.
        do_reset();
        for (int i = 0; i < 5; i++) load(i, mk(i, 10 + i, 0, 1));
        load(5, NOP_WORD);
        load(6, mk(1, 21, 4, 4));
        load(7, HALT_WORD);
        do_reset();
        run_cycles(2);
        step(0, 0, 1, 5, mk(0, 20, 2, 3));
        step(0, 0, 0, 0, 18'h0);
        step(0, 0, 0, 0, 18'h0);
        step(0, 1, 1, 6, mk(0, 22, 20, 20));
        run_cycles(10);

        // rst in the middle of a stall.
        do_reset();
        load(0, mk(0, 5, 1, 2));
        load(1, mk(1, 6, 5, 3));
        load(2, HALT_WORD);
        do_reset();
        run_cycles(2);
        step(1, 1, 0, 0, 18'h0);
        run_cycles(6);

        // Randomized programs on a small register set to provoke hazards.
        for (int round = 0; round < 20; round++) begin
            do_reset();
            for (int a = 0; a < 16; a++) begin
                if ($urandom_range(0, 19) == 0)
                    load(a, HALT_WORD);
                else
                    load(a, mk($urandom_range(0, 7), $urandom_range(0, 3),
                               $urandom_range(0, 3), $urandom_range(0, 3)));
            end
            for (int c = 0; c < 40; c++) begin
                bit rn;
                bit r;
                rn = ($urandom_range(0, 7) != 0);
                r  = ($urandom_range(0, 59) == 0);
                step(r, rn, ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
                     mk($urandom_range(0, 7), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3)));
            end
        end

        // Drain and report.
        repeat (3) @(posedge clk);
        #4;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
